// File: rtl/pad_bank_filtered_pkg.sv
// Shared limits and helpers for the filtered GPIO pad bank.
package pad_bank_filtered_pkg;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int FILTER_MIN = 1;
  localparam int FILTER_MAX = 255;

  // Counter must hold 0..filter_cycles-1; never narrower than one bit.
  function automatic int filt_cnt_width(input int filter_cycles);
    return (filter_cycles < 2) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/pad_bit_filter.sv
// One pad bit: input synchroniser, consecutive-sample glitch filter and
// one-cycle rise/fall pulses aligned with the first cycle of the new level.
module pad_bit_filter
  import pad_bank_filtered_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pad_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("pad_bit_filter: SYNC_STAGES out of range");
  end
  if (FILTER_CYCLES < FILTER_MIN || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
    $error("pad_bit_filter: FILTER_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw pad into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
  end

  // Accept a new level only after it has differed from the held level for
  // FILTER_CYCLES consecutive samples; any return to the held level restarts.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset clears everything so no pulse is produced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = filt_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pad_bank_filtered.sv
// WIDTH-bit bidirectional GPIO bank: registered drive with per-bit
// open-drain, and a synchronised, glitch-filtered input path per bit.
module pad_bank_filtered
  import pad_bank_filtered_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] out_en,
  input  logic [WIDTH-1:0] od_mode,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] in_rise,
  output logic [WIDTH-1:0] in_fall,
  inout  wire  [WIDTH-1:0] padio
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pad_bank_filtered: WIDTH out of range");
  end

  logic [WIDTH-1:0] o_q, o_d;
  logic [WIDTH-1:0] oe_q, oe_d;

  // Open-drain bits only ever drive low; a 1 releases the pad to the pull.
  always_comb begin
    o_d  = out_data & ~od_mode;
    oe_d = out_en & ~(od_mode & out_data);
  end

  // Output and output-enable registers; reset tri-states every pad.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_q  <= '0;
      oe_q <= '0;
    end else begin
      o_q  <= o_d;
      oe_q <= oe_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Behaviour of the shell's single-bit bidirectional buffer.
    assign padio[i] = oe_q[i] ? o_q[i] : 1'bz;

    pad_bit_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clock  (clock),
      .reset_n(reset_n),
      .pad_in (padio[i]),
      .level  (in_data[i]),
      .rise   (in_rise[i]),
      .fall   (in_fall[i])
    );
  end

endmodule

// File: tb/tb_pad_bank_filtered.sv
// Scoreboard bench for pad_bank_filtered: a reference model predicts each
// cycle's outputs from pad history, a monitor compares after every edge.
module tb_pad_bank_filtered;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int FC = 4;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] out_data = '0;
  logic [W-1:0] out_en   = '0;
  logic [W-1:0] od_mode  = '0;
  logic [W-1:0] ext_oe   = '0;
  logic [W-1:0] ext_val  = '0;
  logic [W-1:0] in_data, in_rise, in_fall;
  wire  [W-1:0] padio;

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign padio[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    pullup pu (padio[i]);
  end

  pad_bank_filtered #(
    .WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(FC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .out_data(out_data),
    .out_en  (out_en),
    .od_mode (od_mode),
    .in_data (in_data),
    .in_rise (in_rise),
    .in_fall (in_fall),
    .padio   (padio)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pad;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] pad_hist[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_filt = '0;
  logic [W-1:0] m_drv  = '0;
  logic [W-1:0] m_lvl  = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pad level seen by the world: bank drive wins, else external driver, else pull-up.
  function automatic logic [W-1:0] pad_level(input logic [W-1:0] drv, input logic [W-1:0] lvl);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++)
      r[i] = drv[i] ? lvl[i] : (ext_oe[i] ? ext_val[i] : 1'b1);
    return r;
  endfunction

  // Reference model: predict outputs after the coming rising edge.
  always @(negedge clock) begin
    exp_t         e;
    logic [W-1:0] p, s, flip;
    if (!reset_n) begin
      sb.delete();
      pad_hist.delete();
      s_hist.delete();
      m_filt = '0;
      m_drv  = '0;
      m_lvl  = '0;
    end else begin
      p = pad_level(m_drv, m_lvl);
      pad_hist.push_back(p);
      s = (pad_hist.size() > SS) ? pad_hist[pad_hist.size()-1-SS] : '0;
      s_hist.push_back(s);
      flip = '0;
      if (s_hist.size() >= FC) begin
        flip = '1;
        for (int j = 0; j < FC; j++)
          flip &= s_hist[s_hist.size()-1-j] ^ m_filt;
      end
      e.rise = flip & ~m_filt;
      e.fall = flip & m_filt;
      m_filt = m_filt ^ flip;
      e.data = m_filt;
      for (int i = 0; i < W; i++) begin
        if (od_mode[i]) begin
          m_drv[i] = out_en[i] && !out_data[i];
          m_lvl[i] = 1'b0;
        end else begin
          m_drv[i] = out_en[i];
          m_lvl[i] = out_data[i];
        end
      end
      e.pad = pad_level(m_drv, m_lvl);
      sb.push_back(e);
      if (pad_hist.size() > 32) void'(pad_hist.pop_front());
      if (s_hist.size() > 32) void'(s_hist.pop_front());
    end
  end

  // Monitor: compare DUT outputs just after each rising edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("in_data", in_data, e.data);
      chk("in_rise", in_rise, e.rise);
      chk("in_fall", in_fall, e.fall);
      chk("padio",   padio,   e.pad);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_level(input string name, input logic [W-1:0] target, input int exp_edges);
    int n = 0;
    while (in_data !== target && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_int(name, n, exp_edges);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    cyc(3);
    chk("rst_in_data", in_data, 8'h00);
    chk("rst_in_rise", in_rise, 8'h00);
    chk("rst_in_fall", in_fall, 8'h00);
    chk("rst_pad_z",   padio,   8'hFF);

    // Release with pads pulled high: rise after SS+FC edges.
    reset_n = 1'b1;
    wait_level("rise_latency", 8'hFF, SS + FC);
    chk("rise_pulse", in_rise, 8'hFF);
    @(posedge clock); #1;
    chk("rise_pulse_end", in_rise, 8'h00);
    #1;

    // Push-pull drive on the low nibble.
    out_en = 8'h0F; out_data = 8'h05; od_mode = 8'h00;
    @(posedge clock); #1;
    chk("pp_pad", padio, 8'hF5);
    #1;
    cyc(10);

    // Open-drain: zeros pulled low, ones released to the pull-ups.
    od_mode = 8'hFF; out_en = 8'hFF; out_data = 8'hA5;
    @(posedge clock); #1;
    chk("od_pad", padio, 8'hA5);
    #1;
    cyc(10);

    // Release everything, then glitch bit 2 low for FC-1 and FC cycles.
    out_en = 8'h00; od_mode = 8'h00; out_data = 8'h00;
    cyc(10);
    ext_val = 8'h00; ext_oe = 8'h04;
    cyc(FC - 1);
    ext_oe = 8'h00;
    cyc(10);
    chk("glitch_hold", in_data, 8'hFF);
    ext_oe = 8'h04;
    cyc(FC);
    ext_oe = 8'h00;
    cyc(12);

    // Reset with bit 0 three samples into a pending fall.
    ext_oe = 8'h01;
    cyc(SS + 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_data", in_data, 8'h00);
    chk("midrst_pulses",  in_rise | in_fall, 8'h00);
    chk("midrst_pad",     padio, 8'hFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("rst_hold_pulses", in_rise | in_fall, 8'h00);
    end
    #1;
    ext_oe = 8'h00;
    reset_n = 1'b1;
    wait_level("rerise_latency", 8'hFF, SS + FC);
    #1;

    // Random traffic: bank drives the high nibble, external world the low.
    for (int it = 0; it < 200; it++) begin
      out_en   = {4'($urandom_range(0, 15)), 4'h0};
      out_data = 8'($urandom_range(0, 255));
      od_mode  = 8'($urandom_range(0, 255));
      ext_oe   = {4'h0, 4'($urandom_range(0, 15))};
      ext_val  = 8'($urandom_range(0, 255));
      hold     = $urandom_range(1, FC + 2);
      cyc(hold);
    end
    ext_oe = 8'h00; out_en = 8'h00;
    cyc(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
